// File: rtl/nios2_ocimem_arbiter.sv
// nios2_ocimem_arbiter
// Shares the single-port on-chip debug RAM between the JTAG debug slave
// (system-clock action pulses) and the CPU-side Avalon-MM debug_mem slave.
// JTAG pulses never stall: one request can be parked while the CPU owns the RAM.
// When both sides want the RAM in the same cycle, the side not served last wins.
// Optional feature macro: OCIMEM_CPU_WP_EN. When it is defined, CPU writes made
// outside debug mode are acknowledged but never reach the RAM.
module nios2_ocimem_arbiter #(
   parameter int                ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] JADDR_RST = {ADDR_W{1'b0}}
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              take_action_ocimem_a,
   input  logic              take_action_ocimem_b,
   input  logic              take_no_action_ocimem_a,
   input  logic [37:0]       jdo,
   input  logic              debugack,
   output logic [31:0]       MonDReg,
   output logic              monitor_ready,
   output logic              monitor_error,
   input  logic [ADDR_W-1:0] avs_address,
   input  logic              avs_read,
   input  logic              avs_write,
   input  logic [31:0]       avs_writedata,
   input  logic [3:0]        avs_byteenable,
   output logic [31:0]       avs_readdata,
   output logic              avs_waitrequest,
   output logic [ADDR_W-1:0] ram_addr,
   output logic              ram_wren,
   output logic [3:0]        ram_byteen,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_JRD  = 2'd1,
      ST_CRD  = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic              pending_q, pending_d;
   logic              op_wr_q, op_wr_d;
   logic [31:0]       wdata_q, wdata_d;
   logic [ADDR_W-1:0] ptr_q, ptr_d;
   logic [31:0]       mon_q, mon_d;
   logic              ready_q, ready_d;
   logic              error_q, error_d;
   logic              last_jtag_q, last_jtag_d;
   logic [31:0]       rdata_q, rdata_d;

   logic              cpu_wr_allow_s;
   logic              unused_s;
   logic              jacc_pulse_s;
   logic              jtag_busy_s;
   logic              jacc_accept_s;
   logic              jacc_drop_s;
   logic              jreq_s;
   logic              jwr_s;
   logic [31:0]       jdata_s;
   logic              creq_s;
   logic              idle_s;
   logic              grant_j_s;
   logic              grant_c_s;
   logic              jtag_done_s;

`ifdef OCIMEM_CPU_WP_EN
   assign cpu_wr_allow_s = debugack;
   assign unused_s       = ^{jdo[37:36], jdo[2:0]};
`else
   assign cpu_wr_allow_s = 1'b1;
   assign unused_s       = ^{jdo[37:36], jdo[2:0], debugack};
`endif

   // A pulse seen while a JTAG op is parked or being read back is dropped;
   // an accepted pulse may be granted in its own cycle, so it counts as a request.
   assign jacc_pulse_s  = take_action_ocimem_b | take_no_action_ocimem_a;
   assign jtag_busy_s   = pending_q | (state_q == ST_JRD);
   assign jacc_accept_s = jacc_pulse_s & ~jtag_busy_s;
   assign jacc_drop_s   = jacc_pulse_s & jtag_busy_s;
   assign jreq_s        = pending_q | jacc_accept_s;
   assign jwr_s         = pending_q ? op_wr_q : (take_action_ocimem_b & jdo[35]);
   assign jdata_s       = pending_q ? wdata_q : jdo[34:3];
   // A read and a write issued together are treated as a write.
   assign creq_s        = avs_read | avs_write;
   // Nothing is granted while reset is asserted, so the RAM and the bus stay quiet.
   assign idle_s        = (state_q == ST_IDLE) & reset_n;
   assign grant_j_s     = idle_s & jreq_s & (~creq_s | ~last_jtag_q);
   assign grant_c_s     = idle_s & creq_s & (~jreq_s | last_jtag_q);
   assign jtag_done_s   = (grant_j_s & jwr_s) | (state_q == ST_JRD);

   // Arbitration, RAM port drive, Avalon handshake and JTAG bookkeeping.
   always_comb begin
      state_d         = state_q;
      pending_d       = pending_q;
      op_wr_d         = op_wr_q;
      wdata_d         = wdata_q;
      ptr_d           = ptr_q;
      mon_d           = mon_q;
      ready_d         = ready_q;
      error_d         = error_q;
      last_jtag_d     = last_jtag_q;
      rdata_d         = rdata_q;
      ram_addr        = avs_address;
      ram_wren        = 1'b0;
      ram_byteen      = avs_byteenable;
      ram_wdata       = avs_writedata;
      avs_waitrequest = 1'b1;
      avs_readdata    = rdata_q;

      case (state_q)
         ST_IDLE: begin
            if (grant_j_s) begin
               last_jtag_d = 1'b1;
               ram_addr    = ptr_q;
               ram_byteen  = 4'hF;
               ram_wdata   = jdata_s;
               if (jwr_s) begin
                  ram_wren = 1'b1;
               end else begin
                  state_d = ST_JRD;
               end
            end else if (grant_c_s) begin
               last_jtag_d = 1'b0;
               if (avs_write) begin
                  ram_wren        = cpu_wr_allow_s;
                  avs_waitrequest = 1'b0;
               end else begin
                  state_d = ST_CRD;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_JRD: begin
            mon_d   = ram_rdata;
            state_d = ST_IDLE;
         end
         ST_CRD: begin
            avs_waitrequest = 1'b0;
            avs_readdata    = ram_rdata;
            rdata_d         = ram_rdata;
            state_d         = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Accepted pulse: clear ready, park the op unless it was granted at once.
      if (jacc_accept_s) begin
         ready_d = 1'b0;
         if (!grant_j_s) begin
            pending_d = 1'b1;
            op_wr_d   = take_action_ocimem_b & jdo[35];
            wdata_d   = jdo[34:3];
         end else begin
            pending_d = 1'b0;
         end
      end else if (grant_j_s) begin
         pending_d = 1'b0;
      end else begin
         pending_d = pending_d;
      end

      if (jtag_done_s) begin
         ready_d = 1'b1;
         ptr_d   = ptr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
      end else begin
         ptr_d = ptr_q;
      end

      // A pointer load overrides a same-cycle increment.
      if (take_action_ocimem_a) begin
         ptr_d   = jdo[ADDR_W+16:17];
         error_d = 1'b0;
      end else begin
         error_d = error_q;
      end

      if (jacc_drop_s) begin
         error_d = 1'b1;
      end else begin
         error_d = error_d;
      end
   end

   // State and holding registers; reset aborts any access in progress.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         pending_q   <= 1'b0;
         op_wr_q     <= 1'b0;
         wdata_q     <= 32'h0000_0000;
         ptr_q       <= JADDR_RST;
         mon_q       <= 32'h0000_0000;
         ready_q     <= 1'b0;
         error_q     <= 1'b0;
         last_jtag_q <= 1'b0;
         rdata_q     <= 32'h0000_0000;
      end else begin
         state_q     <= state_d;
         pending_q   <= pending_d;
         op_wr_q     <= op_wr_d;
         wdata_q     <= wdata_d;
         ptr_q       <= ptr_d;
         mon_q       <= mon_d;
         ready_q     <= ready_d;
         error_q     <= error_d;
         last_jtag_q <= last_jtag_d;
         rdata_q     <= rdata_d;
      end
   end

   assign MonDReg       = mon_q;
   assign monitor_ready = ready_q;
   assign monitor_error = error_q;

endmodule

// File: tb/tb_nios2_ocimem_arbiter.sv
// Directed bench for nios2_ocimem_arbiter with a behavioural single-port RAM.
// RAM preload: word i = i * 0x01010101, except word 0 = 0xA5A5A5A5.
module tb_nios2_ocimem_arbiter;

   logic        clk = 1'b0;
   logic        reset_n;
   logic        take_action_ocimem_a, take_action_ocimem_b, take_no_action_ocimem_a;
   logic [37:0] jdo;
   logic        debugack;
   logic [31:0] MonDReg;
   logic        monitor_ready, monitor_error;
   logic [7:0]  avs_address;
   logic        avs_read, avs_write;
   logic [31:0] avs_writedata;
   logic [3:0]  avs_byteenable;
   logic [31:0] avs_readdata;
   logic        avs_waitrequest;
   logic [7:0]  ram_addr;
   logic        ram_wren;
   logic [3:0]  ram_byteen;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata;

   logic [31:0] mem [0:255];
   bit          mem_loaded = 1'b0;
   int          errors = 0;
   int          checks = 0;

   always #5 clk = ~clk;

   nios2_ocimem_arbiter #(.ADDR_W(8), .JADDR_RST(8'h00)) dut (
      .clk(clk), .reset_n(reset_n),
      .take_action_ocimem_a(take_action_ocimem_a),
      .take_action_ocimem_b(take_action_ocimem_b),
      .take_no_action_ocimem_a(take_no_action_ocimem_a),
      .jdo(jdo), .debugack(debugack),
      .MonDReg(MonDReg), .monitor_ready(monitor_ready), .monitor_error(monitor_error),
      .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
      .avs_writedata(avs_writedata), .avs_byteenable(avs_byteenable),
      .avs_readdata(avs_readdata), .avs_waitrequest(avs_waitrequest),
      .ram_addr(ram_addr), .ram_wren(ram_wren), .ram_byteen(ram_byteen),
      .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
   );

   // Behavioural RAM: preloads on the first edge, byte-enabled write, 1-cycle read.
   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int i = 0; i < 256; i++) mem[i] <= 32'h0101_0101 * i;
         mem[0]     <= 32'hA5A5_A5A5;
         mem_loaded <= 1'b1;
      end else if (ram_wren) begin
         for (int b = 0; b < 4; b++)
            if (ram_byteen[b]) mem[ram_addr][b*8 +: 8] <= ram_wdata[b*8 +: 8];
      end
      ram_rdata <= mem[ram_addr];
   end

   task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [37:0] jdo_ptr(input logic [7:0] a);
      logic [37:0] j;
      j        = 38'h0;
      j[24:17] = a;
      return j;
   endfunction

   function automatic logic [37:0] jdo_wr(input logic [31:0] d);
      return {2'b00, 1'b1, d, 3'b000};
   endfunction

   task automatic jtag_ptr(input logic [7:0] a);
      take_action_ocimem_a = 1'b1;
      jdo                  = jdo_ptr(a);
      step();
      take_action_ocimem_a = 1'b0;
      jdo                  = 38'h0;
   endtask

   task automatic jtag_read_at(input string tag, input logic [7:0] a, input logic [31:0] d);
      take_no_action_ocimem_a = 1'b1;
      @(negedge clk);
      check_val({tag, "_addr"}, {24'h0, ram_addr}, {24'h0, a});
      step();
      take_no_action_ocimem_a = 1'b0;
      check_val({tag, "_rdy_clr"}, {31'h0, monitor_ready}, 32'h0);
      step();
      check_val({tag, "_data"}, MonDReg, d);
      check_val({tag, "_rdy"}, {31'h0, monitor_ready}, 32'h1);
   endtask

   logic [3:0] wait_exp;

   initial begin
      reset_n = 1'b0;
      take_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0; take_no_action_ocimem_a = 1'b0;
      jdo = 38'h0; debugack = 1'b1;
      avs_address = 8'h07; avs_read = 1'b0; avs_write = 1'b1;
      avs_writedata = 32'h0; avs_byteenable = 4'hF;
      repeat (3) step();
      @(negedge clk);
      check_val("rst_mondreg", MonDReg, 32'h0);
      check_val("rst_ready", {31'h0, monitor_ready}, 32'h0);
      check_val("rst_error", {31'h0, monitor_error}, 32'h0);
      check_val("rst_waitreq", {31'h0, avs_waitrequest}, 32'h1);
      check_val("rst_readdata", avs_readdata, 32'h0);
      check_val("rst_wren", {31'h0, ram_wren}, 32'h0);
      avs_write = 1'b0;
      step();
      reset_n = 1'b1;
      step();

      // JTAG write at 0x10
      jtag_ptr(8'h10);
      take_action_ocimem_b = 1'b1;
      jdo = jdo_wr(32'hDEAD_BEEF);
      @(negedge clk);
      check_val("jwr_wren", {31'h0, ram_wren}, 32'h1);
      check_val("jwr_addr", {24'h0, ram_addr}, 32'h10);
      check_val("jwr_wdata", ram_wdata, 32'hDEAD_BEEF);
      check_val("jwr_byteen", {28'h0, ram_byteen}, 32'hF);
      step();
      take_action_ocimem_b = 1'b0;
      jdo = 38'h0;
      check_val("jwr_ready", {31'h0, monitor_ready}, 32'h1);
      check_val("jwr_mem", mem[8'h10], 32'hDEAD_BEEF);

      // Pointer advanced to 0x11; then read back 0x10
      jtag_read_at("jrd_inc", 8'h11, 32'h1111_1111);
      jtag_ptr(8'h10);
      jtag_read_at("jrd_10", 8'h10, 32'hDEAD_BEEF);

      // Wrap 0xFF -> 0x00
      jtag_ptr(8'hFF);
      jtag_read_at("wrap_ff", 8'hFF, 32'hFFFF_FFFF);
      jtag_read_at("wrap_00", 8'h00, 32'hA5A5_A5A5);

      // CPU writes: full word, then partial byte enables
      avs_write = 1'b1; avs_address = 8'h20; avs_writedata = 32'h1234_5678; avs_byteenable = 4'hF;
      @(negedge clk);
      check_val("cwr_waitreq", {31'h0, avs_waitrequest}, 32'h0);
      check_val("cwr_wren", {31'h0, ram_wren}, 32'h1);
      step();
      avs_address = 8'h21; avs_writedata = 32'hAAAA_5555; avs_byteenable = 4'h3;
      step();
      avs_write = 1'b0; avs_byteenable = 4'hF;
      check_val("cwr_mem", mem[8'h20], 32'h1234_5678);
      check_val("cwr_be_mem", mem[8'h21], 32'h2121_5555);

      // Contention, last served CPU: JTAG read of 0x01 first, CPU 3 cycles later
      wait_exp = 4'b0111;
      avs_read = 1'b1; avs_address = 8'h20;
      take_no_action_ocimem_a = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         check_val($sformatf("conA_wait%0d", k), {31'h0, avs_waitrequest}, {31'h0, wait_exp[k]});
         if (k == 0) check_val("conA_jaddr", {24'h0, ram_addr}, 32'h01);
         if (k == 3) check_val("conA_rdata", avs_readdata, 32'h1234_5678);
         step();
         take_no_action_ocimem_a = 1'b0;
      end
      avs_read = 1'b0;
      check_val("conA_mon", MonDReg, 32'h0101_0101);

      // Make JTAG the last served, then contention serves CPU first
      jtag_read_at("pre_conB", 8'h02, 32'h0202_0202);
      avs_read = 1'b1; avs_address = 8'h20;
      take_no_action_ocimem_a = 1'b1;
      @(negedge clk);
      check_val("conB_wait0", {31'h0, avs_waitrequest}, 32'h1);
      check_val("conB_caddr", {24'h0, ram_addr}, 32'h20);
      step();
      take_no_action_ocimem_a = 1'b0;
      @(negedge clk);
      check_val("conB_wait1", {31'h0, avs_waitrequest}, 32'h0);
      check_val("conB_rdata", avs_readdata, 32'h1234_5678);
      step();
      avs_read = 1'b0;
      @(negedge clk);
      check_val("conB_jaddr", {24'h0, ram_addr}, 32'h03);
      step();
      step();
      check_val("conB_mon", MonDReg, 32'h0303_0303);
      check_val("conB_rdy", {31'h0, monitor_ready}, 32'h1);

      // Overrun: second ocimem_b while the first is parked behind a CPU read
      avs_read = 1'b1; avs_address = 8'h20;
      take_action_ocimem_b = 1'b1; jdo = jdo_wr(32'h1111_2222);
      step();
      jdo = jdo_wr(32'h3333_4444);
      step();
      take_action_ocimem_b = 1'b0; jdo = 38'h0; avs_read = 1'b0;
      check_val("ovr_error", {31'h0, monitor_error}, 32'h1);
      step();
      check_val("ovr_mem4", mem[8'h04], 32'h1111_2222);
      check_val("ovr_mem5", mem[8'h05], 32'h0505_0505);
      check_val("ovr_rdy", {31'h0, monitor_ready}, 32'h1);
      jtag_ptr(8'h30);
      check_val("ovr_clr", {31'h0, monitor_error}, 32'h0);

      // Reset while the JTAG read is in JRD
      take_no_action_ocimem_a = 1'b1;
      step();
      take_no_action_ocimem_a = 1'b0;
      reset_n = 1'b0;
      #1;
      check_val("mrst_ready", {31'h0, monitor_ready}, 32'h0);
      check_val("mrst_mon", MonDReg, 32'h0);
      check_val("mrst_readdata", avs_readdata, 32'h0);
      check_val("mrst_waitreq", {31'h0, avs_waitrequest}, 32'h1);
      step();
      @(negedge clk);
      reset_n = 1'b1;
      step();
      check_val("mrst_ready2", {31'h0, monitor_ready}, 32'h0);
      avs_read = 1'b1; avs_address = 8'h20;
      @(negedge clk);
      check_val("mrst_idle_w0", {31'h0, avs_waitrequest}, 32'h1);
      step();
      @(negedge clk);
      check_val("mrst_idle_w1", {31'h0, avs_waitrequest}, 32'h0);
      step();
      avs_read = 1'b0;
      jtag_read_at("mrst_ptr", 8'h00, 32'hA5A5_A5A5);

      // CPU write outside debug mode
      debugack = 1'b0;
      avs_write = 1'b1; avs_address = 8'h05; avs_writedata = 32'h0000_1234; avs_byteenable = 4'hF;
      @(negedge clk);
      check_val("wp_waitreq", {31'h0, avs_waitrequest}, 32'h0);
`ifdef OCIMEM_CPU_WP_EN
      check_val("wp_wren", {31'h0, ram_wren}, 32'h0);
`else
      check_val("wp_wren", {31'h0, ram_wren}, 32'h1);
`endif
      step();
      avs_write = 1'b0;
`ifdef OCIMEM_CPU_WP_EN
      check_val("wp_mem", mem[8'h05], 32'h0505_0505);
`else
      check_val("wp_mem", mem[8'h05], 32'h0000_1234);
`endif

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
